// File: rtl/avg_pkg.sv
// +------------------------------------------------------------------+
// | avg_pkg: shared AVG line-segment types and default widths         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package avg_pkg;

    localparam int AVG_COORD_W = 13;
    localparam int AVG_Z_W     = 4;

    typedef struct packed {
        logic                   frame_end;
        logic [AVG_Z_W-1:0]     z;
        logic [AVG_COORD_W-1:0] sx;
        logic [AVG_COORD_W-1:0] sy;
        logic [AVG_COORD_W-1:0] ex;
        logic [AVG_COORD_W-1:0] ey;
    } line_t;

endpackage

`default_nettype wire

// File: rtl/avg_line_mem.sv
// +------------------------------------------------------------------+
// | avg_line_mem: register-array line storage, sync write, async read |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module avg_line_mem
    import avg_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = $bits(line_t)
) (
    input  logic                     clk_in,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/avg_line_fifo.sv
// +------------------------------------------------------------------+
// | avg_line_fifo: show-ahead line FIFO, AVG core -> rasteriser       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module avg_line_fifo
    import avg_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int COORD_W   = AVG_COORD_W,
    parameter int Z_W       = AVG_Z_W,
    parameter int AFULL_LVL = 28,
    parameter int EDGE_WR   = 1
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_req,
    input  logic [COORD_W-1:0]       wr_sx,
    input  logic [COORD_W-1:0]       wr_sy,
    input  logic [COORD_W-1:0]       wr_ex,
    input  logic [COORD_W-1:0]       wr_ey,
    input  logic [Z_W-1:0]           wr_z,
    input  logic                     wr_frame_end,
    output logic                     wr_ready,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [COORD_W-1:0]       rd_sx,
    output logic [COORD_W-1:0]       rd_sy,
    output logic [COORD_W-1:0]       rd_ex,
    output logic [COORD_W-1:0]       rd_ey,
    output logic [Z_W-1:0]           rd_z,
    output logic                     rd_frame_end,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic [15:0]              overflow_cnt
);

    localparam int  AW      = $clog2(DEPTH);
    localparam int  CW      = AW + 1;
    localparam int  LW      = 1 + Z_W + 4 * COORD_W;
    localparam bit  EDGE_EN = (EDGE_WR != 0);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_r;
    logic [15:0]   ovf_r;
    logic          wr_req_q;
    logic          frame_done_r;

    logic          push;
    logic          pop;
    logic          full;
    logic          accept;
    logic          drop;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    logic [LW-1:0] head;

    // Edge mode masks the strobe with last cycle's request level.
    assign push   = wr_req & ~(EDGE_EN & wr_req_q);
    assign full   = (count_r == CW'(DEPTH));
    assign rd_valid = (count_r != '0);
    assign pop    = rd_valid & rd_ready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    assign wr_ready     = ~full;
    assign almost_full  = (count_r >= CW'(AFULL_LVL));
    assign count        = count_r;
    assign overflow_cnt = ovf_r;
    assign frame_done   = frame_done_r;

    // Stored word uses the line_t field order: {frame_end, z, sx, sy, ex, ey}.
    assign wdata = {wr_frame_end, wr_z, wr_sx, wr_sy, wr_ex, wr_ey};
    assign head  = rd_valid ? rdata : '0;
    assign {rd_frame_end, rd_z, rd_sx, rd_sy, rd_ex, rd_ey} = head;

    avg_line_mem #(
        .DEPTH (DEPTH),
        .WIDTH (LW)
    ) u_mem (
        .clk_in (clk_in),
        .we     (accept & ~flush & ~rst),
        .waddr  (wr_ptr),
        .wdata  (wdata),
        .raddr  (rd_ptr),
        .rdata  (rdata)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count_r      <= '0;
            ovf_r        <= '0;
            wr_req_q     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            wr_req_q <= wr_req;
            if (flush) begin
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count_r      <= '0;
                frame_done_r <= 1'b0;
            end else begin
                if (accept) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({accept, pop})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
                if (drop && ovf_r != 16'hFFFF) begin
                    ovf_r <= ovf_r + 16'd1;
                end
                frame_done_r <= pop & rd_frame_end;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_avg_line_fifo.sv
// +------------------------------------------------------------------+
// | tb_avg_line_fifo: directed bench, edge-mode and small level-mode  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_avg_line_fifo;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Edge-mode instance, default geometry
    logic        e_flush = 0, e_wr_req = 0, e_wr_frame_end = 0, e_rd_ready = 0;
    logic [12:0] e_wr_sx = 0, e_wr_sy = 0, e_wr_ex = 0, e_wr_ey = 0;
    logic [3:0]  e_wr_z = 0;
    logic        e_wr_ready, e_rd_valid, e_rd_frame_end, e_frame_done, e_almost_full;
    logic [12:0] e_rd_sx, e_rd_sy, e_rd_ex, e_rd_ey;
    logic [3:0]  e_rd_z;
    logic [5:0]  e_count;
    logic [15:0] e_ovf;

    // Level-mode instance, DEPTH=4, AFULL_LVL=3
    logic        l_flush = 0, l_wr_req = 0, l_wr_frame_end = 0, l_rd_ready = 0;
    logic [12:0] l_wr_sx = 0, l_wr_sy = 0, l_wr_ex = 0, l_wr_ey = 0;
    logic [3:0]  l_wr_z = 0;
    logic        l_wr_ready, l_rd_valid, l_rd_frame_end, l_frame_done, l_almost_full;
    logic [12:0] l_rd_sx, l_rd_sy, l_rd_ex, l_rd_ey;
    logic [3:0]  l_rd_z;
    logic [2:0]  l_count;
    logic [15:0] l_ovf;

    avg_line_fifo #(.DEPTH(32), .COORD_W(13), .Z_W(4), .AFULL_LVL(28), .EDGE_WR(1)) dut_e (
        .clk_in(clk_in), .rst(rst), .flush(e_flush), .wr_req(e_wr_req),
        .wr_sx(e_wr_sx), .wr_sy(e_wr_sy), .wr_ex(e_wr_ex), .wr_ey(e_wr_ey),
        .wr_z(e_wr_z), .wr_frame_end(e_wr_frame_end), .wr_ready(e_wr_ready),
        .rd_valid(e_rd_valid), .rd_ready(e_rd_ready),
        .rd_sx(e_rd_sx), .rd_sy(e_rd_sy), .rd_ex(e_rd_ex), .rd_ey(e_rd_ey),
        .rd_z(e_rd_z), .rd_frame_end(e_rd_frame_end), .frame_done(e_frame_done),
        .count(e_count), .almost_full(e_almost_full), .overflow_cnt(e_ovf)
    );

    avg_line_fifo #(.DEPTH(4), .COORD_W(13), .Z_W(4), .AFULL_LVL(3), .EDGE_WR(0)) dut_l (
        .clk_in(clk_in), .rst(rst), .flush(l_flush), .wr_req(l_wr_req),
        .wr_sx(l_wr_sx), .wr_sy(l_wr_sy), .wr_ex(l_wr_ex), .wr_ey(l_wr_ey),
        .wr_z(l_wr_z), .wr_frame_end(l_wr_frame_end), .wr_ready(l_wr_ready),
        .rd_valid(l_rd_valid), .rd_ready(l_rd_ready),
        .rd_sx(l_rd_sx), .rd_sy(l_rd_sy), .rd_ex(l_rd_ex), .rd_ey(l_rd_ey),
        .rd_z(l_rd_z), .rd_frame_end(l_rd_frame_end), .frame_done(l_frame_done),
        .count(l_count), .almost_full(l_almost_full), .overflow_cnt(l_ovf)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Level-instance entry derived from one tag value.
    task automatic drive_l(input int v);
        l_wr_sx = 13'(v);
        l_wr_sy = 13'(v + 1);
        l_wr_ex = 13'(v + 2);
        l_wr_ey = 13'(v + 3);
        l_wr_z  = 4'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (e_count !== 6'd0) begin bad++; $display("FAIL reset_e_count got=%0d exp=0", e_count); end
        total++; if (e_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_e_rd_valid got=%b exp=0", e_rd_valid); end
        total++; if (e_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_e_wr_ready got=%b exp=1", e_wr_ready); end
        total++; if (e_almost_full !== 1'b0) begin bad++; $display("FAIL reset_e_afull got=%b exp=0", e_almost_full); end
        total++; if (e_rd_sx !== 13'd0 || e_rd_z !== 4'd0) begin bad++; $display("FAIL reset_e_rd_fields got sx=%0d z=%0d exp=0", e_rd_sx, e_rd_z); end
        total++; if (e_ovf !== 16'd0 || e_frame_done !== 1'b0) begin bad++; $display("FAIL reset_e_ovf_fd got ovf=%0d fd=%b exp=0", e_ovf, e_frame_done); end
        total++; if (l_count !== 3'd0 || l_rd_valid !== 1'b0 || l_wr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_l got count=%0d valid=%b ready=%b exp=0/0/1", l_count, l_rd_valid, l_wr_ready);
        end
    endtask

    task automatic test_edge_mode();
        e_wr_sx = 13'd100; e_wr_sy = 13'd200; e_wr_ex = 13'd300; e_wr_ey = 13'd400; e_wr_z = 4'd7;
        e_wr_req = 1'b1;
        tick();
        total++; if (e_count !== 6'd1) begin bad++; $display("FAIL edge_first_count got=%0d exp=1", e_count); end
        tick();
        tick();
        e_wr_req = 1'b0;
        total++; if (e_count !== 6'd1) begin bad++; $display("FAIL edge_held_count got=%0d exp=1", e_count); end
        total++; if (e_rd_valid !== 1'b1) begin bad++; $display("FAIL edge_rd_valid got=%b exp=1", e_rd_valid); end
        total++; if (e_rd_sx !== 13'd100 || e_rd_sy !== 13'd200 || e_rd_ex !== 13'd300 || e_rd_ey !== 13'd400 || e_rd_z !== 4'd7) begin
            bad++; $display("FAIL edge_rd_fields got=%0d,%0d,%0d,%0d,%0d exp=100,200,300,400,7", e_rd_sx, e_rd_sy, e_rd_ex, e_rd_ey, e_rd_z);
        end
        total++; if (e_ovf !== 16'd0) begin bad++; $display("FAIL edge_ovf got=%0d exp=0", e_ovf); end
        e_rd_ready = 1'b1;
        tick();
        e_rd_ready = 1'b0;
        total++; if (e_count !== 6'd0 || e_rd_valid !== 1'b0) begin bad++; $display("FAIL edge_pop got count=%0d valid=%b exp=0/0", e_count, e_rd_valid); end
    endtask

    task automatic test_level_fill();
        int exp_cnt;
        l_wr_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_l(i + 1);
            tick();
            exp_cnt = (i + 1 > 4) ? 4 : i + 1;
            total++; if (l_count !== 3'(exp_cnt)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, l_count, exp_cnt); end
            total++; if (l_almost_full !== (exp_cnt >= 3)) begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, l_almost_full, exp_cnt >= 3); end
            total++; if (l_wr_ready !== (exp_cnt < 4)) begin bad++; $display("FAIL fill_wr_ready[%0d] got=%b exp=%b", i, l_wr_ready, exp_cnt < 4); end
        end
        l_wr_req = 1'b0;
        total++; if (l_ovf !== 16'd1) begin bad++; $display("FAIL fill_ovf got=%0d exp=1", l_ovf); end
        l_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (l_rd_valid !== 1'b1 || l_rd_sx !== 13'(i + 1) || l_rd_ey !== 13'(i + 4)) begin
                bad++; $display("FAIL fill_drain[%0d] got valid=%b sx=%0d ey=%0d exp=1/%0d/%0d", i, l_rd_valid, l_rd_sx, l_rd_ey, i + 1, i + 4);
            end
            tick();
        end
        l_rd_ready = 1'b0;
        total++; if (l_count !== 3'd0 || l_rd_valid !== 1'b0 || l_rd_sx !== 13'd0) begin
            bad++; $display("FAIL fill_empty got count=%0d valid=%b sx=%0d exp=0/0/0", l_count, l_rd_valid, l_rd_sx);
        end
    endtask

    task automatic test_full_push_pop();
        l_wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_l(11 + i);
            tick();
        end
        total++; if (l_count !== 3'd4) begin bad++; $display("FAIL fpp_full got=%0d exp=4", l_count); end
        l_rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_l(15 + i);
            total++; if (l_rd_sx !== 13'(11 + i)) begin bad++; $display("FAIL fpp_head[%0d] got=%0d exp=%0d", i, l_rd_sx, 11 + i); end
            tick();
            total++; if (l_count !== 3'd4) begin bad++; $display("FAIL fpp_count[%0d] got=%0d exp=4", i, l_count); end
        end
        l_wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (l_rd_sx !== 13'(17 + i)) begin bad++; $display("FAIL fpp_tail[%0d] got=%0d exp=%0d", i, l_rd_sx, 17 + i); end
            tick();
        end
        l_rd_ready = 1'b0;
        total++; if (l_count !== 3'd0 || l_ovf !== 16'd1) begin bad++; $display("FAIL fpp_end got count=%0d ovf=%0d exp=0/1", l_count, l_ovf); end
    endtask

    task automatic test_empty_push_ready();
        drive_l(77);
        l_wr_req   = 1'b1;
        l_rd_ready = 1'b1;
        tick();
        l_wr_req = 1'b0;
        total++; if (l_count !== 3'd1 || l_rd_valid !== 1'b1) begin bad++; $display("FAIL epr_count got count=%0d valid=%b exp=1/1", l_count, l_rd_valid); end
        total++; if (l_rd_sx !== 13'd77 || l_rd_z !== 4'd13) begin bad++; $display("FAIL epr_data got sx=%0d z=%0d exp=77/13", l_rd_sx, l_rd_z); end
        tick();
        l_rd_ready = 1'b0;
        total++; if (l_count !== 3'd0) begin bad++; $display("FAIL epr_pop got=%0d exp=0", l_count); end
    endtask

    task automatic test_frame_end();
        l_wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_l(40 + i);
            l_wr_frame_end = (i == 2);
            tick();
        end
        l_wr_req = 1'b0;
        l_wr_frame_end = 1'b0;
        l_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                total++; if (l_rd_frame_end !== (i == 2)) begin bad++; $display("FAIL fe_tag[%0d] got=%b exp=%b", i, l_rd_frame_end, i == 2); end
            end
            tick();
            total++; if (l_frame_done !== (i == 2)) begin bad++; $display("FAIL fe_done[%0d] got=%b exp=%b", i, l_frame_done, i == 2); end
        end
        l_rd_ready = 1'b0;
    endtask

    task automatic test_flush();
        l_wr_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_l(30 + i);
            tick();
        end
        l_wr_req = 1'b0;
        total++; if (l_ovf !== 16'd5) begin bad++; $display("FAIL flush_pre_ovf got=%0d exp=5", l_ovf); end
        l_rd_ready = 1'b1;
        tick();
        tick();
        total++; if (l_count !== 3'd2) begin bad++; $display("FAIL flush_pre_count got=%0d exp=2", l_count); end
        drive_l(99);
        l_flush = 1'b1; l_wr_req = 1'b1; l_rd_ready = 1'b1;
        tick();
        l_flush = 1'b0; l_wr_req = 1'b0; l_rd_ready = 1'b0;
        total++; if (l_count !== 3'd0 || l_rd_valid !== 1'b0 || l_rd_sx !== 13'd0) begin
            bad++; $display("FAIL flush_clear got count=%0d valid=%b sx=%0d exp=0/0/0", l_count, l_rd_valid, l_rd_sx);
        end
        total++; if (l_ovf !== 16'd5) begin bad++; $display("FAIL flush_ovf got=%0d exp=5", l_ovf); end
        drive_l(55);
        l_wr_req = 1'b1;
        tick();
        l_wr_req = 1'b0;
        total++; if (l_count !== 3'd1 || l_rd_sx !== 13'd55 || l_rd_ey !== 13'd58) begin
            bad++; $display("FAIL flush_repush got count=%0d sx=%0d ey=%0d exp=1/55/58", l_count, l_rd_sx, l_rd_ey);
        end
    endtask

    task automatic test_flush_edge_hold();
        e_wr_req = 1'b1;
        tick();
        total++; if (e_count !== 6'd1) begin bad++; $display("FAIL fedge_push got=%0d exp=1", e_count); end
        e_flush = 1'b1;
        tick();
        e_flush = 1'b0;
        tick();
        tick();
        total++; if (e_count !== 6'd0) begin bad++; $display("FAIL fedge_no_retrigger got=%0d exp=0", e_count); end
        e_wr_req = 1'b0;
        tick();
        e_wr_req = 1'b1;
        tick();
        e_wr_req = 1'b0;
        total++; if (e_count !== 6'd1 || e_rd_sx !== 13'd100) begin bad++; $display("FAIL fedge_new_edge got count=%0d sx=%0d exp=1/100", e_count, e_rd_sx); end
    endtask

    initial begin
        test_reset();
        test_edge_mode();
        test_level_fill();
        test_full_push_pop();
        test_empty_push_ready();
        test_frame_end();
        test_flush();
        test_flush_edge_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/avg_line_fifo.md
Name: avg_line_fifo

Overview:
- Parametrised line-segment FIFO between the AVG core's line-write output and the vector rasteriser/DAC driver.
- Successor to the fixed 32-entry line queue. Adds:
  - valid/ready read handshake
  - configurable depth, coordinate and intensity widths
  - level or edge write mode
  - push-while-full with simultaneous pop
  - overflow accounting, almost-full, flush and end-of-frame tagging.

Parameters:
- DEPTH, 32: entry count; power of two, >= 2.
- COORD_W, 13: width of each of sx, sy, ex, ey.
- Z_W, 4: intensity width.
- AFULL_LVL, 28: almost_full asserts when count >= AFULL_LVL; legal range 1..DEPTH.
- EDGE_WR, 1:
  - 1 = one push per rising edge of wr_req.
  - 0 = one push per cycle wr_req is high.

Ports:
- clk_in  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of queue contents
- wr_req  in  1  write request (edge or level per EDGE_WR)
- wr_sx, wr_sy, wr_ex, wr_ey  in  COORD_W each  line endpoints
- wr_z  in  Z_W  intensity
- wr_frame_end  in  1  tags entry as last line of frame (core halt)
- wr_ready  out  1  = !full
- rd_valid  out  1  head entry present
- rd_ready  in  1  consumer accepts head
- rd_sx, rd_sy, rd_ex, rd_ey  out  COORD_W each  head endpoints
- rd_z  out  Z_W  head intensity
- rd_frame_end  out  1  head frame tag
- frame_done  out  1  one-cycle pulse when a frame_end entry is popped
- count  out  $clog2(DEPTH)+1  occupancy
- almost_full  out  1  count >= AFULL_LVL
- overflow_cnt  out  16  dropped pushes, saturating

Behaviour:
- Reset (rst high at clk_in edge) sets:
  - rd_ptr = 0, wr_ptr = 0, count = 0, overflow_cnt = 0
  - frame_done = 0, edge-detect history wr_req_q = 0
  - Resulting outputs: rd_valid 0, wr_ready 1, almost_full 0, all rd_* fields 0.
  - rst overrides flush, push and pop.
- Push strobe:
  - EDGE_WR=1: push = wr_req & ~wr_req_q, where wr_req_q <= wr_req every cycle.
  - EDGE_WR=0: push = wr_req.
- pop = rd_valid & rd_ready.
- rd_valid = (count != 0).
- Read side is show-ahead: rd_* present mem[rd_ptr] combinationally, and are forced to 0 while count == 0.
- Write-to-read latency: an entry pushed at edge N is visible with rd_valid = 1 after edge N (1 cycle).
- Accept rule: push is accepted if count < DEPTH, or if pop occurs in the same cycle.
  - Accepted: mem[wr_ptr] <= entry; wr_ptr++.
- Drop rule: push while full with no pop is dropped. overflow_cnt++, saturating at 16'hFFFF. Contents are untouched.
- Pop: rd_ptr++.
- Count update:
  - +1 on accepted push without pop
  - -1 on pop without push
  - unchanged on both or neither
- Empty + push + rd_ready: no pop occurs (rd_valid was 0). Count becomes 1.
- Full + push + pop: both occur. Count stays DEPTH and FIFO order is preserved.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The full/empty distinction comes from count only.
- frame_done is registered: it is 1 in the cycle after a pop whose head had rd_frame_end = 1, otherwise 0.
- Flush:
  - Next edge: rd_ptr = wr_ptr = 0, count = 0, frame_done = 0.
  - Any same-cycle push and pop are discarded and not counted as overflow.
  - overflow_cnt and wr_req_q are preserved, so a level held across flush does not re-trigger in edge mode.
- almost_full and wr_ready are combinational from registered count.
- Storage is not reset. Only pointers and count are.

Decomposition:
- Shared package avg_pkg holds:
  - localparam defaults AVG_COORD_W = 13, AVG_Z_W = 4.
  - typedef struct packed line_t {frame_end, z, sx, sy, ex, ey}, sized from these.
  - The core, this FIFO and the rasteriser all use line_t.
- One sub-module: avg_line_mem.
  - DEPTH x $bits(line_t) register array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
- FIFO control (pointers, count, edge detect, overflow, frame_done) stays in avg_line_fifo.

Test Plan:
- Edge mode, hold wr_req 3 cycles with sx=100, sy=200, ex=300, ey=400, z=7 -> exactly one entry. count=1 one cycle later, rd_valid=1, rd_* match, overflow_cnt=0.
- EDGE_WR=0, DEPTH=4, AFULL_LVL=3, push 5 consecutive cycles with rd_ready=0:
  - almost_full rises when count=3.
  - wr_ready=0 at count=4.
  - 5th push dropped, overflow_cnt=1.
  - Popping yields entries 1-4 in order.
- Full FIFO (DEPTH=4), push and rd_ready high for 6 cycles -> count stays 4 throughout. Popped sequence is exactly push order. Pointers wrap past 3 correctly.
- Empty FIFO, push with rd_ready=1 same cycle -> no pop. count=1 and the entry is returned on the following pop.
- Push 3 entries, the 3rd with wr_frame_end=1, then drain -> frame_done pulses for exactly 1 cycle, on the cycle after the 3rd pop only.
- count=2, overflow_cnt=5, assert flush together with push and pop -> next cycle count=0, rd_valid=0, overflow_cnt=5. A new push afterwards lands at entry 0 and reads back correctly.
